output_display_driver: RTL and testbench
========================================

Name: output_display_driver

Overview:
- Downstream consumer of the CPU output register (the 8-bit value written by the OUT/DI control word).
- Converts the latched byte to decimal with a sequential double-dabble engine, one shift per cycle.
- Drives a 4-digit multiplexed 7-segment display: sign on digit 3, hundreds/tens/ones on digits 2/1/0.
- Supports unsigned or two's-complement interpretation, with leading-zero blanking.

Parameters:
- REFRESH_DIV, 1000: clk cycles each digit stays enabled before advancing; legal range >= 1.
- SEG_ACTIVE_LOW, 0: 1 inverts all seg outputs.
- AN_ACTIVE_LOW, 1: 1 makes an[] active-low; 0 makes it active-high.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- load  input  1  single-cycle strobe: data_in is valid this cycle.
- data_in  input  8  value from the CPU output register.
- signed_mode  input  1  sampled together with data_in; 1 means two's complement.
- busy  output  1  conversion in progress.
- bcd_out  output  12  registered BCD of the magnitude: {hundreds, tens, ones}.
- negative  output  1  registered sign of the last completed value.
- seg  output  7  {g,f,e,d,c,b,a}; active-high when SEG_ACTIVE_LOW=0.
- an  output  4  one-hot digit enable; an[0] is the ones digit.

Behaviour:
- Reset (rst=1 at an edge):
  - busy=0, bcd_out=0x000, negative=0.
  - Pending slot cleared; FSM goes to IDLE.
  - Refresh counter=0, digit index=0.
  - Resulting outputs: an=4'b1110, seg=7'h3F (display reads "   0").
  - Reset wins over load in the same cycle.
- FSM states:
  - IDLE: load=1 captures the input (accept edge A) and moves to SHIFT, with iteration count i=0.
  - SHIFT: 8 cycles, i=0..7. Each cycle, every BCD nibble >= 5 gets +3, then {bcd[11:0], mag[7:0]} shifts left by 1.
  - SHIFT exits after i=7 to UPDATE.
  - UPDATE: one cycle. Copies the BCD result to bcd_out and the latched sign to negative, then goes to IDLE, or straight back to SHIFT if the pending slot is full (pending is consumed and cleared).
- Timing:
  - busy=1 from A+1 through A+9 inclusive.
  - bcd_out and negative take their new values at edge A+9.
  - busy=0 after A+9 if no pending value.
  - Fixed latency: 9 cycles.
- Magnitude capture:
  - signed_mode=1 and data_in[7]=1: mag = (~data_in + 1) as 8-bit unsigned, and the sign is latched as 1.
  - -128 (0x80) gives mag=128.
  - Otherwise mag = data_in and the sign is 0.
- Load while busy (including the UPDATE cycle):
  - Stored in a one-deep pending slot as {data_in, signed_mode}.
  - A later load overwrites the slot (last value wins); intermediate values are dropped.
  - No load is ever lost while in IDLE.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - The refresh counter is independent of conversion.
- Digit content (combinational from the registered index, bcd_out, and negative):
  - Digit 0: ones, always shown.
  - Digit 1: tens; blank if hundreds=0 and tens=0.
  - Digit 2: hundreds; blank if hundreds=0.
  - Digit 3: '-' (7'h40) if negative, else blank (7'h00).
- Segment patterns for 0-9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Nibble values above 9 are unreachable; they show blank.
- Polarity: parameter inversion is applied after pattern selection.

Test Plan:
- Reset with all inputs 0, then cycle through the refresh with REFRESH_DIV=4:
  - bcd_out=0x000, busy=0.
  - an sequence 1110, 1101, 1011, 0111, each held 4 cycles.
  - seg sequence 3F, 00, 00, 00.
- load data_in=0xFF, signed_mode=0 at edge A:
  - busy=1 over A+1..A+9.
  - bcd_out=0x255, negative=0 at A+9.
  - Digits 2,1,0 = 5B, 6D, 6D; digit 3 = 00.
- load 0xF6, signed_mode=1:
  - bcd_out=0x010, negative=1.
  - Digit 3=40, digit 2=00, digit 1=06, digit 0=3F.
- load 0x80, signed_mode=1:
  - bcd_out=0x128, negative=1.
  - Same 0x80 with signed_mode=0: bcd_out=0x128, negative=0.
- load 7 at A, load 42 at A+3, load 99 at A+5:
  - bcd_out=0x007 at A+9.
  - Conversion restarts at A+10; bcd_out=0x099 at A+18.
  - 42 never appears; busy stays continuously 1 through A+18.
- Reset mid-conversion: rst at A+4 with a pending value queued:
  - busy=0, bcd_out=0x000, and no later update occurs.
  - load 5 after reset gives bcd_out=0x005 at 9-cycle latency.

Source files
------------

// File: rtl/output_display_driver_if.sv
// Bundle between the CPU output register and the display driver: load strobe and byte in,
// conversion status, BCD result and multiplexed 7-segment drive out.
interface output_display_driver_if;
  logic        load;
  logic [7:0]  data_in;
  logic        signed_mode;
  logic        busy;
  logic [11:0] bcd_out;
  logic        negative;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output load, data_in, signed_mode,
    input  busy, bcd_out, negative, seg, an
  );

  modport slave (
    input  load, data_in, signed_mode,
    output busy, bcd_out, negative, seg, an
  );
endinterface

// File: rtl/output_display_driver.sv
// Converts the CPU output byte to sign + 3 BCD digits with a one-shift-per-cycle double-dabble
// engine and scans them onto a 4-digit multiplexed 7-segment display.
module output_display_driver #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  output_display_driver_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, UPDATE = 2'd2} state_t;

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t      state_r, state_s;
  logic [2:0]  iter_r, iter_s;
  logic [7:0]  mag_r, mag_s;
  logic [11:0] bcd_r, bcd_s;
  logic        sign_r, sign_s;
  logic        pend_valid_r, pend_valid_s;
  logic [7:0]  pend_data_r, pend_data_s;
  logic        pend_signed_r, pend_signed_s;
  logic        busy_r;
  logic [11:0] bcd_out_r, bcd_out_s;
  logic        negative_r, negative_s;
  logic [19:0] shifted_s;
  logic [CNT_W-1:0] refresh_cnt_r;
  logic [1:0]  digit_r;
  logic [6:0]  pattern_s;
  logic [3:0]  an_onehot_s;

  // Sign/magnitude split; negating 0x80 wraps back to 0x80, i.e. magnitude 128.
  function automatic logic [8:0] capture(input logic [7:0] d, input logic sm);
    logic [7:0] neg_mag;
    neg_mag = ~d + 8'd1;
    if (sm && d[7]) begin
      return {1'b1, neg_mag};
    end else begin
      return {1'b0, d};
    end
  endfunction

  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int k = 0; k < 3; k++) begin
      if (b[k*4 +: 4] >= 4'd5) begin
        r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
      end else begin
        r[k*4 +: 4] = b[k*4 +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_s       = state_r;
    iter_s        = iter_r;
    mag_s         = mag_r;
    bcd_s         = bcd_r;
    sign_s        = sign_r;
    pend_valid_s  = pend_valid_r;
    pend_data_s   = pend_data_r;
    pend_signed_s = pend_signed_r;
    bcd_out_s     = bcd_out_r;
    negative_s    = negative_r;
    shifted_s     = {dd_adjust(bcd_r), mag_r} << 1;
    case (state_r)
      IDLE: begin
        if (bus.load) begin
          {sign_s, mag_s} = capture(bus.data_in, bus.signed_mode);
          bcd_s = 12'h000; iter_s = 3'd0; state_s = SHIFT; pend_valid_s = 1'b0;
        end else if (pend_valid_r) begin
          {sign_s, mag_s} = capture(pend_data_r, pend_signed_r);
          bcd_s = 12'h000; iter_s = 3'd0; state_s = SHIFT; pend_valid_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        bcd_s  = shifted_s[19:8];
        mag_s  = shifted_s[7:0];
        iter_s = iter_r + 3'd1;
        if (iter_r == 3'd7) begin
          state_s = UPDATE;
        end else begin
          state_s = SHIFT;
        end
      end
      UPDATE: begin
        bcd_out_s  = bcd_r;
        negative_s = sign_r;
        if (pend_valid_r) begin
          {sign_s, mag_s} = capture(pend_data_r, pend_signed_r);
          bcd_s = 12'h000; iter_s = 3'd0; state_s = SHIFT; pend_valid_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
    // Loads arriving while busy land in the slot; a newer one overwrites it.
    if (bus.load && (state_r != IDLE)) begin
      pend_valid_s  = 1'b1;
      pend_data_s   = bus.data_in;
      pend_signed_s = bus.signed_mode;
    end else begin
      pend_valid_s  = pend_valid_s;
    end
  end

  // Conversion state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      iter_r        <= 3'd0;
      mag_r         <= 8'h00;
      bcd_r         <= 12'h000;
      sign_r        <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_data_r   <= 8'h00;
      pend_signed_r <= 1'b0;
      busy_r        <= 1'b0;
      bcd_out_r     <= 12'h000;
      negative_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      iter_r        <= iter_s;
      mag_r         <= mag_s;
      bcd_r         <= bcd_s;
      sign_r        <= sign_s;
      pend_valid_r  <= pend_valid_s;
      pend_data_r   <= pend_data_s;
      pend_signed_r <= pend_signed_s;
      busy_r        <= (state_s != IDLE);
      bcd_out_r     <= bcd_out_s;
      negative_r    <= negative_s;
    end
  end

  // Digit scan timer, free-running regardless of conversion activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_r <= '0;
      digit_r       <= 2'd0;
    end else if (refresh_cnt_r == CNT_LAST) begin
      refresh_cnt_r <= '0;
      digit_r       <= digit_r + 2'd1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
    end
  end

  // Digit content with leading-zero blanking; sign sits on the leftmost digit.
  always_comb begin
    pattern_s = 7'h00;
    case (digit_r)
      2'd0: pattern_s = seg_pat(bcd_out_r[3:0]);
      2'd1: begin
        if (bcd_out_r[11:4] == 8'h00) begin
          pattern_s = 7'h00;
        end else begin
          pattern_s = seg_pat(bcd_out_r[7:4]);
        end
      end
      2'd2: begin
        if (bcd_out_r[11:8] == 4'h0) begin
          pattern_s = 7'h00;
        end else begin
          pattern_s = seg_pat(bcd_out_r[11:8]);
        end
      end
      2'd3: begin
        if (negative_r) begin
          pattern_s = 7'h40;
        end else begin
          pattern_s = 7'h00;
        end
      end
      default: pattern_s = 7'h00;
    endcase
    an_onehot_s = 4'b0001 << digit_r;
  end

  assign bus.busy     = busy_r;
  assign bus.bcd_out  = bcd_out_r;
  assign bus.negative = negative_r;
  assign bus.seg      = SEG_ACTIVE_LOW ? ~pattern_s : pattern_s;
  assign bus.an       = AN_ACTIVE_LOW ? ~an_onehot_s : an_onehot_s;
endmodule

// File: tb/tb_output_display_driver.sv
// Scoreboard bench: stimulus pushes hand-computed results with their due edge; a negedge
// monitor compares busy, bcd_out, negative, an and seg on every cycle.
module tb_output_display_driver;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  logic rst_at_edge;
  int   n_vec = 0;
  int   n_mis = 0;

  typedef struct {
    int          due;
    logic [11:0] bcd;
    logic        neg;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } exp_t;

  exp_t        sb[$];
  logic        armed = 1'b0;
  logic [11:0] cur_bcd;
  logic        cur_neg;
  logic [27:0] cur_segs;
  int          ref_base = 0;
  int          busy_from = 0;
  int          busy_until = 0;

  output_display_driver_if bus();

  output_display_driver #(
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: retire due entries, then check every observable against the current expectation.
  always @(negedge clk) begin
    int idx;
    exp_t e;
    logic [3:0] exp_an;
    if (rst_at_edge === 1'b1) begin
      armed    = 1'b1;
      sb.delete();
      cur_bcd  = 12'h000;
      cur_neg  = 1'b0;
      cur_segs = {7'h00, 7'h00, 7'h00, 7'h3F};
      ref_base = cyc;
    end
    if (armed) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e        = sb.pop_front();
        cur_bcd  = e.bcd;
        cur_neg  = e.neg;
        cur_segs = e.segs;
      end
      idx    = ((cyc - ref_base) / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      chk("busy", 32'(bus.busy), 32'((cyc >= busy_from) && (cyc < busy_until)));
      chk("bcd_out", 32'(bus.bcd_out), 32'(cur_bcd));
      chk("negative", 32'(bus.negative), 32'(cur_neg));
      chk("an", 32'(bus.an), 32'(exp_an));
      chk("seg", 32'(bus.seg), 32'(cur_segs[idx*7 +: 7]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] d, input logic sm);
    bus.load        = 1'b1;
    bus.data_in     = d;
    bus.signed_mode = sm;
    tick(1);
    bus.load        = 1'b0;
    bus.data_in     = 8'h00;
    bus.signed_mode = 1'b0;
  endtask

  task automatic push(input int due, input logic [11:0] bcd, input logic neg, input logic [27:0] segs);
    exp_t e;
    e.due  = due;
    e.bcd  = bcd;
    e.neg  = neg;
    e.segs = segs;
    sb.push_back(e);
  endtask

  // Single isolated conversion: result due 9 edges after the accepting edge.
  task automatic conv(input logic [7:0] d, input logic sm, input logic [11:0] bcd, input logic neg,
                      input logic [27:0] segs);
    int a;
    a          = cyc + 1;
    busy_from  = a;
    busy_until = a + 9;
    push(a + 9, bcd, neg, segs);
    pulse(d, sm);
    tick(12);
  endtask

  initial begin
    int a;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.data_in = 8'h00;
    bus.signed_mode = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);

    conv(8'hFF, 1'b0, 12'h255, 1'b0, {7'h00, 7'h5B, 7'h6D, 7'h6D});
    conv(8'hF6, 1'b1, 12'h010, 1'b1, {7'h40, 7'h00, 7'h06, 7'h3F});
    conv(8'h80, 1'b1, 12'h128, 1'b1, {7'h40, 7'h06, 7'h5B, 7'h7F});
    conv(8'h80, 1'b0, 12'h128, 1'b0, {7'h00, 7'h06, 7'h5B, 7'h7F});
    conv(8'h64, 1'b0, 12'h100, 1'b0, {7'h00, 7'h06, 7'h3F, 7'h3F});
    conv(8'h7F, 1'b1, 12'h127, 1'b0, {7'h00, 7'h06, 7'h5B, 7'h07});

    // 7 at A, 42 at A+3, 99 at A+5: 42 is overwritten in the pending slot.
    a          = cyc + 1;
    busy_from  = a;
    busy_until = a + 18;
    push(a + 9,  12'h007, 1'b0, {7'h00, 7'h00, 7'h00, 7'h07});
    push(a + 18, 12'h099, 1'b0, {7'h00, 7'h00, 7'h6F, 7'h6F});
    pulse(8'd7, 1'b0);
    tick(2);
    pulse(8'd42, 1'b0);
    tick(1);
    pulse(8'd99, 1'b0);
    tick(16);

    // Reset at A+4 with a pending value queued; load asserted with reset must be ignored.
    a          = cyc + 1;
    busy_from  = a;
    busy_until = a + 9;
    push(a + 9, 12'h007, 1'b0, {7'h00, 7'h00, 7'h00, 7'h07});
    pulse(8'd7, 1'b0);
    tick(1);
    pulse(8'd42, 1'b0);
    tick(1);
    busy_until      = a + 4;
    rst             = 1'b1;
    bus.load        = 1'b1;
    bus.data_in     = 8'h33;
    bus.signed_mode = 1'b0;
    tick(1);
    rst         = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 8'h00;
    tick(14);

    conv(8'd5, 1'b0, 12'h005, 1'b0, {7'h00, 7'h00, 7'h00, 7'h6D});
    tick(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
